encrypt_core: RTL and testbench

ENCRYPT_CORE -- requirements
Module: encrypt_core

---
 rtl/encrypt_core_pkg.sv | 81 ++++++++
 rtl/encrypt_core_round.sv | 29 ++
 rtl/keyExpansion.sv | 32 +++
 rtl/encrypt_core.sv | 88 ++++++++
 tb/tb_encrypt_core.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/encrypt_core_pkg.sv
// Shared AES definitions: S-box, Rcon, FSM encoding and legal key/round pairs.
// Used by both the encrypt and decrypt datapaths.
package encrypt_core_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b111};
        return SBOX_FLAT[idx -: 8];
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] r;
        case (n)
            1:       r = 8'h01;
            2:       r = 8'h02;
            3:       r = 8'h04;
            4:       r = 8'h08;
            5:       r = 8'h10;
            6:       r = 8'h20;
            7:       r = 8'h40;
            8:       r = 8'h80;
            9:       r = 8'h1b;
            10:      r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; col holds rows 0..3 from the top byte down.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Legal pairings: nk 4/6/8 map to nr 10/12/14.
    function automatic int nr_for_nk(input int nk);
        return nk + 6;
    endfunction

endpackage

// File: rtl/encrypt_core_round.sv
// One AES forward round; last_round drops MixColumns for the final round.
module encrypt_round
    import encrypt_core_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] state_out
);

    logic [127:0] sr;
    logic [127:0] mc;

    always_comb begin
        sr = '0;
        mc = '0;
        // Byte 4*c+r is row r of column c; ShiftRows pulls from column c+r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sbox(state_in[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
        end
        state_out = (last_round ? sr : mc) ^ round_key;
    end

endmodule

// File: rtl/keyExpansion.sv
// Combinational FIPS-197 key schedule; emits all nr+1 round keys at once.
module keyExpansion
    import encrypt_core_pkg::*;
#(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic [nk*32-1:0]     key,
    output logic [nr:0][127:0]   round_keys
);

    localparam int NW = 4 * (nr + 1);

    // Each schedule word lives in its own generate scope to keep the chain acyclic.
    for (genvar i = 0; i < NW; i++) begin : g_w
        logic [31:0] wd;
        if (i < nk) begin : g_key
            assign wd = key[nk*32-1-32*i -: 32];
        end else if (i % nk == 0) begin : g_rot
            assign wd = g_w[i-nk].wd ^ sub_word(rot_word(g_w[i-1].wd)) ^ {rcon(i / nk), 24'h0};
        end else if (nk > 6 && i % nk == 4) begin : g_sub
            assign wd = g_w[i-nk].wd ^ sub_word(g_w[i-1].wd);
        end else begin : g_xor
            assign wd = g_w[i-nk].wd ^ g_w[i-1].wd;
        end
    end

    for (genvar r = 0; r <= nr; r++) begin : g_rk
        assign round_keys[r] = {g_w[4*r].wd, g_w[4*r+1].wd, g_w[4*r+2].wd, g_w[4*r+3].wd};
    end

endmodule

// File: rtl/encrypt_core.sv
// Iterative AES encryptor, one round per clock, using a captured key register.
// Handshake: start is taken when idle; done pulses one cycle with ciphertext valid.
module encrypt_core
    import encrypt_core_pkg::*;
#(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [nk*32-1:0]  key,
    input  logic [127:0]      plaintext,
    output logic              busy,
    output logic              done,
    output logic [127:0]      ciphertext
);

    fsm_t                 fsm;
    fsm_t                 fsm_next;
    logic [3:0]           round;
    logic [127:0]         state_q;
    logic [nk*32-1:0]     key_q;
    logic [nr:0][127:0]   round_keys;
    logic [127:0]         round_out;
    logic                 last_round;

    keyExpansion #(.nk(nk), .nr(nr)) u_key_exp (
        .key        (key_q),
        .round_keys (round_keys)
    );

    assign last_round = (round == 4'(nr));

    encrypt_round u_round (
        .state_in   (state_q),
        .round_key  (round_keys[round]),
        .last_round (last_round),
        .state_out  (round_out)
    );

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (start) fsm_next = RUN;
            RUN:     if (last_round) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    assign busy = (fsm == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= IDLE;
            round      <= 4'd0;
            state_q    <= '0;
            key_q      <= '0;
            ciphertext <= '0;
            done       <= 1'b0;
        end else begin
            fsm  <= fsm_next;
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        // Round key 0 is the leading 128 bits of the key itself.
                        key_q   <= key;
                        state_q <= plaintext ^ key[nk*32-1 -: 128];
                        round   <= 4'd1;
                    end
                end
                RUN: begin
                    state_q <= round_out;
                    if (last_round) begin
                        ciphertext <= round_out;
                        done       <= 1'b1;
                        round      <= 4'd0;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                default: round <= 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_core.sv
// Directed bench for encrypt_core with FIPS-197 vectors for all three key sizes.
module tb_encrypt_core;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K192   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CTZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start4, start6, start8;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic [127:0] pt;
    logic         busy4, busy6, busy8;
    logic         done4, done6, done8;
    logic [127:0] ct4, ct6, ct8;

    int checks = 0;
    int errors = 0;

    encrypt_core #(.nk(4), .nr(10)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .key(key4), .plaintext(pt),
        .busy(busy4), .done(done4), .ciphertext(ct4)
    );
    encrypt_core #(.nk(6), .nr(12)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .key(key6), .plaintext(pt),
        .busy(busy6), .done(done6), .ciphertext(ct6)
    );
    encrypt_core #(.nk(8), .nr(14)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .key(key8), .plaintext(pt),
        .busy(busy8), .done(done8), .ciphertext(ct8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input int idx);
        case (idx)
            6:       return done6;
            8:       return done8;
            default: return done4;
        endcase
    endfunction

    // Counts edges until done is seen; n stays -1 if the budget runs out.
    task automatic wait_done(input int idx, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (get_done(idx) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int dn;
        int lat;

        rst = 1'b1; start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
        key4 = K128; key6 = K192; key8 = K256; pt = PT;
        tick();
        tick();
        chk("reset_busy", 128'(busy4), 128'd0);
        chk("reset_done", 128'(done4), 128'd0);
        chk("reset_ct4", ct4, 128'd0);
        chk("reset_ct8", ct8, 128'd0);

        // Reset wins over start on the same edge.
        start4 = 1'b1;
        tick();
        chk("rst_prio_busy", 128'(busy4), 128'd0);
        rst = 1'b0; start4 = 1'b0;
        tick();
        chk("idle_after_rst", 128'(busy4), 128'd0);

        // AES-128 single block.
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("aes128_busy", 128'(busy4), 128'd1);
        chk("aes128_ct_hold", ct4, 128'd0);
        wait_done(4, 30, n);
        chk("aes128_latency", 128'(n), 128'd10);
        chk("aes128_ct", ct4, CT128);
        chk("aes128_busy_in_done", 128'(busy4), 128'd0);
        tick();
        chk("aes128_done_one_cycle", 128'(done4), 128'd0);
        chk("aes128_ct_held", ct4, CT128);

        // AES-192 and AES-256.
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        wait_done(6, 30, n);
        chk("aes192_latency", 128'(n), 128'd12);
        chk("aes192_ct", ct6, CT192);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done(8, 30, n);
        chk("aes256_latency", 128'(n), 128'd14);
        chk("aes256_ct", ct8, CT256);

        // start held high; inputs zeroed after the accepting edge.
        key4 = K128; pt = PT; start4 = 1'b1;
        tick();
        key4 = '0; pt = '0;
        wait_done(4, 30, n);
        chk("b2b_first_latency", 128'(n), 128'd10);
        chk("b2b_first_ct", ct4, CT128);
        tick();
        chk("b2b_second_accepted", 128'(busy4), 128'd1);
        wait_done(4, 30, n);
        start4 = 1'b0;
        chk("b2b_second_latency", 128'(n), 128'd10);
        chk("b2b_second_ct", ct4, CTZERO);
        tick();
        chk("b2b_idle", 128'(busy4), 128'd0);

        // Reset mid-flight at E0+5 aborts the block.
        key4 = K128; pt = PT; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done4 === 1'b1) dn++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 128'(busy4), 128'd0);
        chk("abort_done", 128'(done4), 128'd0);
        chk("abort_ct", ct4, 128'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done4 === 1'b1) dn++;
        end
        chk("abort_no_done", 128'(dn), 128'd0);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done(4, 30, n);
        chk("restart_latency", 128'(n), 128'd10);
        chk("restart_ct", ct4, CT128);
        tick();

        // Stray starts at E0+3 and E0+7 with a different key must be ignored.
        key4 = K128; pt = PT; start4 = 1'b1;
        tick();
        start4 = 1'b0; key4 = '0; pt = '0;
        chk("ignore_ct_hold", ct4, CT128);
        dn = 0; lat = -1;
        for (int e = 1; e <= 30; e++) begin
            if (e == 3 || e == 7) start4 = 1'b1;
            tick();
            start4 = 1'b0;
            if (done4 === 1'b1) begin
                dn++;
                if (lat < 0) lat = e;
            end
        end
        chk("ignore_done_count", 128'(dn), 128'd1);
        chk("ignore_latency", 128'(lat), 128'd10);
        chk("ignore_ct", ct4, CT128);
        chk("ignore_idle", 128'(busy4), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
